// File: rtl/alu_board_sequencer.sv
// Board-level sequencer: loads a function code and operands from slide switches
// one debounced button step at a time, launches the unit under test with a
// go/done handshake, then pages the captured result onto the LED bank.
module alu_board_sequencer #(
    parameter int DATA_W     = 32,
    parameter int SW_W       = 8,
    parameter int LED_W      = 16,
    parameter int NUM_OPS    = 2,
    parameter int FUNC_W     = 4,
    parameter int DEB_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SW_W-1:0]           sw,
    input  logic                      step,
    output logic [FUNC_W-1:0]         func,
    output logic [NUM_OPS*DATA_W-1:0] ops,
    output logic                      go,
    input  logic                      done,
    input  logic [DATA_W-1:0]         res,
    output logic [LED_W-1:0]          out
);
    localparam int BPO   = DATA_W / SW_W;
    localparam int NCH   = DATA_W / LED_W;
    localparam int NLOAD = NUM_OPS * BPO;
    localparam int CW    = $clog2(DEB_CYCLES + 1);
    localparam int OIW   = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
    localparam int CIW   = (BPO > 1) ? $clog2(BPO) : 1;
    localparam int PGW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NWW   = $clog2(NLOAD + 3);

    typedef enum logic [2:0] {S_FUNC, S_LOAD, S_WAIT, S_SHOW, S_MARK} state_t;

    // ---------------- step conditioning ----------------
    logic          s1, s2, db, arm, stp;
    logic [CW-1:0] cnt;

    // Synchronise, debounce and edge-detect the button. The synchroniser resets
    // to "pressed" and arm stays low until a low level is seen, so a button held
    // through reset cannot produce a step until it is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1  <= 1'b1;
            s2  <= 1'b1;
            db  <= 1'b0;
            arm <= 1'b0;
            cnt <= '0;
            stp <= 1'b0;
        end else begin
            s1  <= step;
            s2  <= s1;
            stp <= 1'b0;
            if (!s2) arm <= 1'b1;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYCLES - 1)) begin
                cnt <= '0;
                db  <= s2;
                stp <= s2 & arm;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ---------------- sequencer ----------------
    state_t             state, state_d;
    logic [OIW-1:0]     op_idx, op_d;
    logic [CIW-1:0]     chunk_idx, ch_d;
    logic [NWW-1:0]     nwr, nwr_d;
    logic [PGW-1:0]     page, page_d;
    logic [DATA_W-1:0]  rreg, rreg_d;
    logic [LED_W-1:0]   out_d;
    logic               func_we, ld_we, go_d;

    // Next-state and next-register values; the LED value is derived from the
    // next state so that out can itself be a plain register.
    always_comb begin
        state_d = state;
        op_d    = op_idx;
        ch_d    = chunk_idx;
        nwr_d   = nwr;
        page_d  = page;
        rreg_d  = rreg;
        func_we = 1'b0;
        ld_we   = 1'b0;
        go_d    = 1'b0;
        out_d   = LED_W'(1);
        case (state)
            S_FUNC: if (stp) begin
                func_we = 1'b1;
                state_d = S_LOAD;
                op_d    = '0;
                ch_d    = CIW'(BPO - 1);
                nwr_d   = '0;
            end
            S_LOAD: if (stp) begin
                ld_we = 1'b1;
                nwr_d = nwr + 1'b1;
                if (chunk_idx == '0) begin
                    ch_d = CIW'(BPO - 1);
                    op_d = op_idx + 1'b1;
                    if (op_idx == OIW'(NUM_OPS - 1)) begin
                        state_d = S_WAIT;
                        go_d    = 1'b1;
                    end
                end else begin
                    ch_d = chunk_idx - 1'b1;
                end
            end
            // A step arriving together with done is simply dropped here.
            S_WAIT: if (done) begin
                rreg_d  = res;
                page_d  = PGW'(NCH - 1);
                state_d = S_SHOW;
            end
            S_SHOW: if (stp) begin
                if (page == '0) state_d = S_MARK;
                else            page_d  = page - 1'b1;
            end
            S_MARK: if (stp) begin
                state_d = S_SHOW;
                page_d  = PGW'(NCH - 1);
            end
            default: state_d = S_FUNC;
        endcase
        case (state_d)
            S_FUNC:  out_d = LED_W'(1);
            S_LOAD:  out_d = LED_W'(nwr_d) + LED_W'(2);
            S_WAIT:  out_d = LED_W'(NLOAD + 2);
            S_SHOW:  out_d = rreg_d[int'(page_d)*LED_W +: LED_W];
            S_MARK:  out_d = '1;
            default: out_d = LED_W'(1);
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_FUNC;
            op_idx    <= '0;
            chunk_idx <= '0;
            nwr       <= '0;
            page      <= '0;
            rreg      <= '0;
            func      <= '0;
            ops       <= '0;
            go        <= 1'b0;
            out       <= LED_W'(1);
        end else begin
            state     <= state_d;
            op_idx    <= op_d;
            chunk_idx <= ch_d;
            nwr       <= nwr_d;
            page      <= page_d;
            rreg      <= rreg_d;
            go        <= go_d;
            out       <= out_d;
            if (func_we) func <= sw[FUNC_W-1:0];
            if (ld_we)   ops[(int'(op_idx)*BPO + int'(chunk_idx))*SW_W +: SW_W] <= sw;
        end
    end
endmodule

// File: tb/tb_alu_board_sequencer.sv
// Directed bench for alu_board_sequencer: default build plus a narrow
// 16-bit / 3-operand build, each driven by a small model of the unit.
module tb_alu_board_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        step, step2;

    logic [3:0]  func,  func2;
    logic [63:0] ops;
    logic [47:0] ops2;
    logic        go, go2, done, done2;
    logic [31:0] res;
    logic [15:0] res2;
    logic [15:0] out;
    logic [7:0]  out2;

    int nchk  = 0;
    int nfail = 0;
    int gocnt = 0;
    int mode;      // 0: done one cycle after go, 1: done with go, 2: done = fdone
    logic fdone;
    logic go_q;

    always #5 clk = ~clk;

    alu_board_sequencer #(.DEB_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .sw(sw), .step(step), .func(func), .ops(ops),
        .go(go), .done(done), .res(res), .out(out)
    );

    alu_board_sequencer #(.DATA_W(16), .SW_W(8), .LED_W(8), .NUM_OPS(3),
                          .FUNC_W(4), .DEB_CYCLES(4)) dut2 (
        .clk(clk), .rst(rst), .sw(sw), .step(step2), .func(func2), .ops(ops2),
        .go(go2), .done(done2), .res(res2), .out(out2)
    );

    // Unit models: adders with selectable completion latency.
    always @(posedge clk) go_q <= go;
    always @(posedge clk) if (go) gocnt <= gocnt + 1;
    assign done  = (mode == 0) ? go_q : (mode == 1) ? go : fdone;
    assign res   = ops[31:0] + ops[63:32];
    assign done2 = go2;
    assign res2  = ops2[15:0] + ops2[31:16] + ops2[47:32];

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which, input logic [7:0] v, input int hold);
        sw = v;
        if (which == 1) step = 1'b1; else step2 = 1'b1;
        cyc(hold);
        step  = 1'b0;
        step2 = 1'b0;
        cyc(12);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(5);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] ld1 [8];
        logic [7:0] ld2 [8];
        logic [7:0] ld3 [6];
        ld1 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        ld2 = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};
        ld3 = '{8'h12, 8'h34, 8'h01, 8'h01, 8'h00, 8'h11};
        rst = 1'b0; step = 1'b0; step2 = 1'b0; sw = 8'h00; mode = 2; fdone = 1'b0;
        cyc(3);
        chk("rst_out",  out,  16'h0001);
        chk("rst_go",   go,   1'b0);
        chk("rst_func", func, 4'h0);
        chk("rst_ops",  ops,  64'h0);
        chk("rst_out2", out2, 8'h01);
        rst = 1'b1;
        cyc(5);

        // Main load, unit completes only when fdone is pulsed.
        press(1, 8'h02, 12);
        chk("func", func, 4'h2);
        chk("prog_func", out, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            press(1, ld1[i], 12);
            chk($sformatf("prog%0d", i), out, 16'(i + 3));
            if (i == 3) begin
                fdone = 1'b1; cyc(3); fdone = 1'b0; cyc(2);
                chk("spurious_done", out, 16'h0006);
            end
        end
        chk("ops", ops, 64'h9ABCDEF0_12345678);
        chk("go_once", gocnt, 1);
        fdone = 1'b1; cyc(1); fdone = 1'b0;
        chk("page_ms", out, 16'hACF1);
        press(1, 8'h00, 12);
        chk("page_ls", out, 16'h3568);
        press(1, 8'h00, 12);
        chk("marker", out, 16'hFFFF);
        press(1, 8'h00, 12);
        chk("loop", out, 16'hACF1);

        // Bounce and long hold.
        step = 1'b1; cyc(3); step = 1'b0; cyc(20);
        chk("glitch", out, 16'hACF1);
        press(1, 8'h00, 100);
        chk("hold", out, 16'h3568);

        // Reset mid-load.
        do_reset();
        mode = 0;
        press(1, 8'h02, 12);
        for (int i = 0; i < 4; i++) press(1, ld1[i], 12);
        chk("midload_prog", out, 16'h0006);
        rst = 1'b0; #1;
        chk("midload_out",  out,  16'h0001);
        chk("midload_go",   go,   1'b0);
        chk("midload_ops",  ops,  64'h0);
        chk("midload_func", func, 4'h0);
        cyc(2); rst = 1'b1; cyc(5);

        // Button held through reset release gives no step.
        step = 1'b1; cyc(2);
        rst = 1'b0; cyc(2); rst = 1'b1;
        cyc(30);
        chk("held_reset", out, 16'h0001);
        step = 1'b0; cyc(15);

        // Fresh load with done one cycle after go.
        press(1, 8'h07, 12);
        for (int i = 0; i < 8; i++) press(1, ld1[i], 12);
        chk("reload_func", func, 4'h7);
        chk("reload_res",  out,  16'hACF1);
        chk("reload_go",   gocnt, 2);

        // Reset mid-WAIT.
        do_reset();
        mode = 2;
        press(1, 8'h01, 12);
        for (int i = 0; i < 8; i++) press(1, ld1[i], 12);
        chk("wait_prog", out, 16'h000A);
        rst = 1'b0; #1;
        chk("midwait_out", out, 16'h0001);
        chk("midwait_ops", ops, 64'h0);
        cyc(2); rst = 1'b1; cyc(5);

        // Zero-latency unit, carry across the page boundary.
        mode = 1;
        press(1, 8'h0F, 12);
        for (int i = 0; i < 8; i++) press(1, ld2[i], 12);
        chk("zl_ops", ops, 64'h00000001_0000FFFF);
        chk("zl_ms", out, 16'h0001);
        chk("zl_go", gocnt, 4);
        press(1, 8'h00, 12);
        chk("zl_ls", out, 16'h0000);
        press(1, 8'h00, 12);
        chk("zl_mark", out, 16'hFFFF);
        press(1, 8'h00, 12);
        chk("zl_loop", out, 16'h0001);

        // Narrow build: 6 load steps, 2 pages, marker FF.
        press(2, 8'h03, 12);
        chk("n_func", func2, 4'h3);
        chk("n_prog_func", out2, 8'h02);
        for (int i = 0; i < 6; i++) begin
            press(2, ld3[i], 12);
            if (i < 5) chk($sformatf("n_prog%0d", i), out2, 8'(i + 3));
        end
        chk("n_ops", ops2, 48'h0011_0101_1234);
        chk("n_ms", out2, 8'h13);
        press(2, 8'h00, 12);
        chk("n_ls", out2, 8'h46);
        press(2, 8'h00, 12);
        chk("n_mark", out2, 8'hFF);
        press(2, 8'h00, 12);
        chk("n_loop", out2, 8'h13);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
